if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage of the RISC-V pipeline: it owns the PC, issues requests to instruction memory, and loads the IF/ID pipeline register. It consumes the branch decision resolved in ID: the taken flag and target produced by the ID branch comparator and adder. On a taken branch it redirects the PC and squashes the wrong-path slot. It also honours the hazard unit's stall.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented to ID

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hazard-unit stall; freezes PC and IF/ID
- branch_taken  in  1  branch/jump resolved taken in ID (valid only with id_valid)
- branch_target  in  32  redirect address from ID
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, always equal to pc
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr
- imem_rdata  in  32  fetched instruction
- id_valid  out  1  IF/ID slot holds a real instruction
- id_pc  out  32  PC of the IF/ID instruction
- id_instr  out  32  IF/ID instruction (NOP_INSTR when invalid)
- fetch_misalign  out  1  one-cycle pulse: redirect target had [1:0]≠0

## Operation
- States: BOOT, FETCH, WAIT.
- Reset: BOOT. pc=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP_INSTR, fetch_misalign=0, imem_req=0.
- BOOT -> FETCH after one cycle. No request is issued in BOOT.
- FETCH/WAIT: imem_req = ~stall.
- Handshake completes on an edge where imem_req & imem_ready. IF/ID loads {1, pc, imem_rdata}; pc += 4 (mod 2^32, wraps FFFF_FFFC -> 0); state is FETCH.
- Request but no ready: IF/ID loads bubble (id_valid=0, id_instr=NOP_INSTR, id_pc holds); pc holds; state is WAIT.
- Priority per edge: stall > redirect > handshake.
- stall=1: pc, IF/ID and state all hold. branch_taken is ignored. imem_req=0.
- Redirect (branch_taken & id_valid & ~stall):
  - pc <= {branch_target[31:2],2'b00}.
  - IF/ID loads the bubble. Any concurrent handshake is discarded.
  - State -> FETCH.
  - fetch_misalign <= |branch_target[1:0]; otherwise it is 0 next cycle.
- branch_taken with id_valid=0 is ignored.
- Redirect while in WAIT abandons the pending request. imem must tolerate an address change while not ready.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously), including from WAIT.

## Timing
- Fetch latency: address issued in cycle N with ready=1 -> instruction visible on id_* in cycle N+1.
- Back-to-back: one instruction per cycle when ready=1 and no stall.
- Branch penalty: exactly one bubble. Redirect edge at N; target fetched in cycle N+1; target appears on id_* in cycle N+2.
- No combinational path from branch_taken or branch_target to imem_addr (pc registered). imem_req depends combinationally only on stall and state.

## Configuration
- IF_PERF_CNT_EN defined:
  - Adds output redirect_cnt (32) counting accepted redirects.
  - Adds output wait_cnt (32) counting edges that end in WAIT.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package (if_pkg): state enum {BOOT, FETCH, WAIT}, default NOP_INSTR constant, PC_INC=4.
- One natural sub-module: if_id_reg, the IF/ID register with load/hold/bubble controls. PC and state logic stay in the top.

## Test plan
- Reset release, ready=1, memory[i]=0x100+i -> BOOT one cycle, then id_pc 0,4,8 with id_instr 0x100,0x101,0x102; id_valid=1 from the third cycle after release.
- ready low for 3 cycles at pc=0x8 -> id_valid=0 for 3 cycles, imem_addr stays 0x8, wait_cnt=3 (with IF_PERF_CNT_EN).
- id_valid=1, branch_taken=1, target 0x40 -> the next id slot is a bubble (NOP_INSTR), then id_pc=0x40; redirect_cnt increments.
- stall=1 with branch_taken=1 for 2 cycles -> pc and id_* hold, imem_req=0. On release with branch_taken still 1 -> redirect to target.
- target 0x42 -> pc=0x40, fetch_misalign high exactly one cycle.
- pc=0xFFFF_FFFC handshake -> pc wraps to 0x0; assert rst_n low while in WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_INC  = 32'd4;

  function automatic logic [31:0] align4(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // a bubble keeps the old pc so ID still sees a stable address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (bubble_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem request and IF/ID load.
// Optional perf counters enabled by IF_PERF_CNT_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        fetch_misalign
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] wait_cnt
`endif
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic        misalign_q;
  logic        redirect;
  logic        hs;
  logic        load;
  logic        bubble;

  assign imem_req  = (state_q != BOOT) & ~stall;
  assign imem_addr = pc_q;

  assign redirect = branch_taken & id_valid & ~stall;
  assign hs       = imem_req & imem_ready;
  // a redirect discards any handshake on the same edge
  assign load     = hs & ~redirect;
  assign bubble   = redirect | (imem_req & ~imem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (stall) begin
        state_q <= state_q;
      end else if (state_q == BOOT) begin
        state_q <= FETCH;
      end else if (redirect) begin
        state_q    <= FETCH;
        pc_q       <= align4(branch_target);
        misalign_q <= |branch_target[1:0];
      end else if (hs) begin
        state_q <= FETCH;
        pc_q    <= pc_q + PC_INC;
      end else begin
        state_q <= WAIT;
      end
    end
  end

  assign fetch_misalign = misalign_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .bubble_i (bubble),
    .pc_i     (pc_q),
    .instr_i  (imem_rdata),
    .valid_o  (id_valid),
    .pc_o     (id_pc),
    .instr_o  (id_instr)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] wait_cnt_q;
  logic        ends_wait;

  // stalling inside WAIT still ends the edge in WAIT
  assign ends_wait =
    (stall & (state_q == WAIT)) |
    (imem_req & ~imem_ready & ~redirect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= 32'h0;
      wait_cnt_q     <= 32'h0;
    end else begin
      if (redirect)
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (ends_wait)
        wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign wait_cnt     = wait_cnt_q;
`endif

endmodule
